// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 6-stage core: arbitrates data-memory wait, mispredict
// flush, EX and ID stalls into one stall vector, with bus timeout and perf counters.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             ex_flush_req_i,
    input  logic [31:0]      ex_redirect_pc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int unsigned TMO_W = 8;
    localparam int unsigned PC_W  = 32;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                pend_q, pend_d;
    logic [PC_W-1:0]     pend_pc_q, pend_pc_d;
    logic                mem_err_q, mem_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                mem_stall;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Data-memory handshake: stall until ack or until the wait budget runs out.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        mem_stall = 1'b0;
        mem_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i && !mem_ack_i) begin
                    mem_stall = 1'b1;
                    state_d   = ST_WAIT;
                    tmo_d     = TMO_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else if (tmo_q >= TMO_LIMIT) begin
                    state_d   = ST_IDLE;
                    tmo_d     = '0;
                    mem_err_d = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    tmo_d     = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    // Stall/flush arbitration; a flush seen while frozen is parked until release.
    always_comb begin
        stall_o   = STALL_NONE;
        flush_o   = 1'b0;
        new_pc_o  = '0;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (mem_stall) begin
            stall_o = STALL_MEM;
            if (ex_flush_req_i && !pend_q) begin
                pend_d    = 1'b1;
                pend_pc_d = ex_redirect_pc_i;
            end
        end else if (pend_q || ex_flush_req_i) begin
            flush_o  = 1'b1;
            new_pc_o = pend_q ? pend_pc_q : ex_redirect_pc_i;
            pend_d   = 1'b0;
        end else if (stallreq_ex_i) begin
            stall_o = STALL_EX;
        end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
        end
        if (rst) begin
            stall_o  = STALL_NONE;
            flush_o  = 1'b0;
            new_pc_o = '0;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o[0] && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_o && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign mem_err_o      = mem_err_q;
    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline sequencer for the 6-stage core (PC, IF, ID, EX, MEM, WB). It drives the stall vector consumed by every pipeline register, including the EX/MEM register.
- It arbitrates between these sources, highest first: data-memory wait (handshake FSM), branch-mispredict flush, EX multi-cycle stall and ID load-use stall.
- It latches flush requests that arrive while the pipeline is frozen, enforces a data-bus timeout, and keeps stall and flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, number of WAIT cycles without ack before the access is abandoned (range 2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous reset, active-high
- stallreq_id_i  input  1  load-use hazard from ID
- stallreq_ex_i  input  1  EX multi-cycle unit busy
- mem_req_i  input  1  MEM stage holds a load/store this cycle
- mem_ack_i  input  1  data bus completes the access this cycle
- ex_flush_req_i  input  1  one-cycle mispredict pulse from EX
- ex_redirect_pc_i  input  32  correct PC, valid with ex_flush_req_i
- stall_o  output  6  bit k=1 holds stage k (0=PC … 5=WB); register k inserts a bubble when stall[k]=1 and stall[k+1]=0
- flush_o  output  1  discard IF/ID and ID/EX contents, load new_pc_o
- new_pc_o  output  32  redirect target, valid when flush_o=1
- mem_err_o  output  1  one-cycle pulse: access timed out
- stall_cycles_o  output  CNT_W  cycles with stall_o[0]=1, saturating
- flush_count_o  output  CNT_W  number of flush_o pulses, saturating

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; timeout counter = 0; pend_flush = 0; pend_pc = 0.
  - stall_o=6'b000000, flush_o=0, new_pc_o=0, mem_err_o=0, both counters = 0.
  - Asserting rst mid-WAIT abandons the access and drops any pending flush.
- stall_o, flush_o and new_pc_o are combinational from the current state and inputs, so they act in the same cycle. mem_err_o and the counters are registered.
- Memory FSM:
  - IDLE:
    - mem_req_i=1 with mem_ack_i=0 → stall_o=011111 this cycle, go to WAIT, counter=1.
    - mem_req_i=1 with mem_ack_i=1 → zero-wait access, no mem stall, stay in IDLE.
  - WAIT:
    - stall_o=011111 while mem_ack_i=0; counter increments each cycle.
    - mem_ack_i=1 → stall released that cycle, go to IDLE.
    - counter reaches MEM_TIMEOUT with no ack → stall released that cycle, mem_err_o=1 next cycle, go to IDLE.
    - mem_ack_i=1 on the timeout cycle counts as success: no error.
- Priority when no mem stall is active:
  1. Pending or incoming flush → stall_o=000000, flush_o=1. new_pc_o = pend_pc if pend_flush=1, else ex_redirect_pc_i.
  2. stallreq_ex_i → stall_o=001111.
  3. stallreq_id_i → stall_o=000111.
  4. Otherwise stall_o=000000.
- Flush beats any simultaneous ID/EX stall; those requests are dropped for that cycle.
- Flush during a mem stall:
  - ex_flush_req_i is captured into pend_flush/pend_pc and flush_o stays 0.
  - The flush is issued on the first cycle the mem stall is not asserted (the ack or timeout cycle); pend_flush clears at the next edge.
  - A second pulse while pend_flush=1 is ignored: the oldest flush wins.
- Counters:
  - stall_cycles_o increments on every edge where stall_o[0]=1.
  - flush_count_o increments on every cycle where flush_o=1.
  - Both hold at all-ones and never wrap.
- There are no X outputs: with no requests active, all outputs are 0.

Test Plan:
- Reset: assert rst mid-WAIT (after 3 stalled cycles) → stall_o=0, counters=0, state IDLE immediately, no mem_err_o pulse afterwards.
- Mem wait: mem_req_i=1 with ack after 4 cycles → stall_o=011111 for exactly 4 cycles, released on the ack cycle, stall_cycles_o=4.
- Zero-wait access: mem_req_i=1 and mem_ack_i=1 in the same cycle → stall_o=000000, FSM stays IDLE.
- Flush priority and pending:
  - ex_flush_req_i pulse with pc=0x0000_0100 together with stallreq_id_i=1 → flush_o=1, stall_o=0, new_pc_o=0x100.
  - Same pulse during a mem wait → flush_o=1 with new_pc_o=0x100 on the ack cycle only; flush_count_o increments by 1 each time.
- Timeout: MEM_TIMEOUT=16, no ack → stall held for 16 cycles, mem_err_o pulses once on the next cycle, FSM returns to IDLE. A variant with ack on cycle 16 → no error.
- Priority and saturation:
  - stallreq_ex_i and stallreq_id_i together → stall_o=001111.
  - Preload the counters near all-ones (CNT_W=4) → they hold at 4'hF.
